// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with runtime frame format and show-ahead RX FIFO
//
// Purpose:
//   Receives asynchronous serial frames on rx_serial. The line is sampled at
//   OS_RATE ticks per bit; the tick period is cfg_div+1 aclk cycles. Each bit is
//   decided by a 3-sample majority around mid-bit. Frames carry 5-8 data bits,
//   optional even/odd parity and 1 or 2 stop bits. Each frame is stored with its
//   parity, framing and break flags in a show-ahead FIFO.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   rx_serial            serial line, idle high, asynchronous to aclk
//   cfg_en               receiver enable; low aborts any frame in progress
//   cfg_div              aclk cycles per oversample tick, minus 1
//   cfg_data_bits        00=5 .. 11=8 data bits
//   cfg_parity           00 none, 01 even, 10 odd, 11 none
//   cfg_stop2            two stop bits when 1
//   m_valid/m_ready      FIFO head handshake; pop on m_valid && m_ready
//   m_data/m_perr/m_ferr/m_brk  head entry, all zero when FIFO empty
//   fifo_level           number of entries held
//   overrun, ovr_clr     sticky frame-dropped flag and its clear
//   rx_busy              receiver is inside a frame or waiting out a break

module uart_rx_os #(
  parameter int OS_RATE     = 16,
  parameter int DIV_W       = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          rx_serial,
  input  logic                          cfg_en,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [7:0]                    m_data,
  output logic                          m_perr,
  output logic                          m_ferr,
  output logic                          m_brk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  input  logic                          ovr_clr,
  output logic                          rx_busy
);

  localparam int PH_W = $clog2(OS_RATE);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [PH_W-1:0] PH_S0  = PH_W'(OS_RATE / 2 - 1);
  localparam logic [PH_W-1:0] PH_S1  = PH_W'(OS_RATE / 2);
  localparam logic [PH_W-1:0] PH_S2  = PH_W'(OS_RATE / 2 + 1);
  localparam logic [PH_W-1:0] PH_END = PH_W'(OS_RATE - 1);
  localparam logic [PH_W-1:0] PH_ONE = PH_W'(1);
  localparam logic [AW:0]     LVL_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]     LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_BRKWAIT
  } state_t;

  // Synchroniser resets to idle-high so leaving reset never looks like a start bit.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_serial};
    end
  end

  assign w_rx = r_sync[SYNC_STAGES-1];

  state_t           r_state;
  logic [PH_W-1:0]  r_phase;
  logic [DIV_W-1:0] r_tick_cnt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_nbits;   // data bits minus 1
  logic [1:0]       r_par;
  logic             r_stop2;
  logic [2:0]       r_bitidx;
  logic [7:0]       r_data;
  logic             r_s0;
  logic             r_s1;
  logic             r_parbit;
  logic             r_perr;
  logic             r_ferr1;   // first stop bit was 0 (two-stop frames)

  logic w_in_frame;
  logic w_tick;
  logic w_mid;
  logic w_end;
  logic w_bit;
  logic w_par_en;
  logic w_last_stop;
  logic w_all_zero;
  logic w_ferr;
  logic w_brk;
  logic w_push;
  logic [10:0] w_entry;

  assign w_in_frame = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_PARITY) ||
                      (r_state == S_STOP1) || (r_state == S_STOP2);
  assign w_tick     = w_in_frame && (r_tick_cnt == '0);
  assign w_mid      = w_tick && (r_phase == PH_S2);
  assign w_end      = w_tick && (r_phase == PH_END);
  // Third sample is taken live at the deciding tick.
  assign w_bit      = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_par_en   = (r_par == 2'b01) || (r_par == 2'b10);
  assign w_last_stop = (r_state == S_STOP2) || ((r_state == S_STOP1) && !r_stop2);
  assign w_all_zero = (r_data == 8'd0) && !r_parbit;
  assign w_ferr     = !w_bit || ((r_state == S_STOP2) && r_ferr1);
  // Break needs every stop bit low as well as all-zero data and parity.
  assign w_brk      = w_all_zero && !w_bit && ((r_state == S_STOP1) || r_ferr1);
  assign w_push     = cfg_en && w_mid && w_last_stop;
  assign w_entry    = {w_brk, w_ferr, r_perr, r_data};

  // Tick divider sits at reload outside a frame so the first tick after START
  // entry lands a fixed cfg_div cycles later.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tick_cnt <= '0;
    end else if (!cfg_en || !w_in_frame) begin
      r_tick_cnt <= cfg_div;
    end else if (r_tick_cnt == '0) begin
      r_tick_cnt <= r_div;
    end else begin
      r_tick_cnt <= r_tick_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_div    <= '0;
      r_nbits  <= '0;
      r_par    <= '0;
      r_stop2  <= 1'b0;
      r_bitidx <= '0;
      r_data   <= '0;
      r_s0     <= 1'b1;
      r_s1     <= 1'b1;
      r_parbit <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr1  <= 1'b0;
    end else if (!cfg_en) begin
      r_state <= S_IDLE;
    end else begin
      if (w_tick) begin
        r_phase <= (r_phase == PH_END) ? '0 : r_phase + PH_ONE;
        if (r_phase == PH_S0) r_s0 <= w_rx;
        if (r_phase == PH_S1) r_s1 <= w_rx;
      end
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state  <= S_START;
            r_phase  <= '0;
            r_div    <= cfg_div;
            r_nbits  <= 3'd4 + {1'b0, cfg_data_bits};
            r_par    <= cfg_parity;
            r_stop2  <= cfg_stop2;
            r_bitidx <= '0;
            r_data   <= '0;
            r_parbit <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr1  <= 1'b0;
          end
        end
        S_START: begin
          if (w_mid && w_bit) begin
            r_state <= S_IDLE;
          end else if (w_end) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_mid) r_data[r_bitidx] <= w_bit;
          if (w_end) begin
            r_bitidx <= r_bitidx + 3'd1;
            if (r_bitidx == r_nbits) r_state <= w_par_en ? S_PARITY : S_STOP1;
          end
        end
        S_PARITY: begin
          if (w_mid) begin
            r_parbit <= w_bit;
            r_perr   <= (r_par == 2'b01) ? (^r_data ^ w_bit) : ~(^r_data ^ w_bit);
          end
          if (w_end) r_state <= S_STOP1;
        end
        S_STOP1: begin
          if (w_mid) begin
            if (r_stop2) r_ferr1 <= !w_bit;
            else         r_state <= w_brk ? S_BRKWAIT : S_IDLE;
          end else if (w_end && r_stop2) begin
            r_state <= S_STOP2;
          end
        end
        S_STOP2: begin
          if (w_mid) r_state <= w_brk ? S_BRKWAIT : S_IDLE;
        end
        S_BRKWAIT: begin
          if (w_rx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RX FIFO
  logic [10:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_overrun;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr;
  logic [10:0]   w_head;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_pop   = !w_empty && m_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge aclk) begin
    if (w_wr) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + PTR_ONE;
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (w_push && w_full && !w_pop) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign m_valid    = !w_empty;
  assign m_data     = w_empty ? 8'd0 : w_head[7:0];
  assign m_perr     = !w_empty && w_head[8];
  assign m_ferr     = !w_empty && w_head[9];
  assign m_brk      = !w_empty && w_head[10];
  assign fifo_level = r_level;
  assign overrun    = r_overrun;
  assign rx_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - randomized scoreboard bench for uart_rx_os
module tb_uart_rx_os;

  localparam int DEPTH   = 4;
  localparam int BIT_CLK = 64;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        rx_serial;
  logic        cfg_en;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_perr;
  logic        m_ferr;
  logic        m_brk;
  logic [2:0]  fifo_level;
  logic        overrun;
  logic        ovr_clr;
  logic        rx_busy;

  int          n_vec = 0;
  int          n_err = 0;
  logic [10:0] exp_q[$];
  bit          exp_ovr = 1'b0;
  bit          settled = 1'b0;

  always #5 aclk = ~aclk;

  uart_rx_os #(
    .OS_RATE(16),
    .DIV_W(16),
    .FIFO_DEPTH(DEPTH),
    .SYNC_STAGES(2)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .rx_serial(rx_serial),
    .cfg_en(cfg_en),
    .cfg_div(cfg_div),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_perr(m_perr),
    .m_ferr(m_ferr),
    .m_brk(m_brk),
    .fifo_level(fifo_level),
    .overrun(overrun),
    .ovr_clr(ovr_clr),
    .rx_busy(rx_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare: head entry whenever valid; full state once the line is quiet.
  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      if (settled) begin
        chk("level", 32'(fifo_level), 32'(exp_q.size()));
        chk("valid", 32'(m_valid), 32'(exp_q.size() != 0));
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        chk("busy_idle", 32'(rx_busy), 32'd0);
        if (exp_q.size() == 0) chk("empty_head", 32'({m_brk, m_ferr, m_perr, m_data}), 32'd0);
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_entry: got 0x%0h, expected no entry at %0t",
                   {m_brk, m_ferr, m_perr, m_data}, $time);
        end else begin
          chk("head", 32'({m_brk, m_ferr, m_perr, m_data}), 32'(exp_q[0]));
          if (m_ready) void'(exp_q.pop_front());
        end
      end
      if (ovr_clr) exp_ovr = 1'b0;
    end
  end

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (BIT_CLK) @(posedge aclk);
    #1;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Builds the expected entry from the frame rules, then serialises the frame.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic [1:0] par, input bit stop2,
                            input bit pflip, input bit sb1, input bit sb2);
    logic [7:0]  dm;
    logic        pb;
    bit          pen;
    bit          s1;
    bit          s2;
    logic [10:0] e;
    dm  = d & 8'((16'd1 << nb) - 16'd1);
    pen = (par == 2'd1) || (par == 2'd2);
    pb  = ((par == 2'd2) ? ~(^dm) : (^dm)) ^ pflip;
    s1  = !sb1;
    s2  = stop2 ? !sb2 : 1'b1;
    e[7:0] = dm;
    e[8]   = pen && pflip;
    e[9]   = !s1 || !s2;
    e[10]  = (dm == 8'd0) && (!pen || !pb) && !s1 && (!stop2 || !s2);
    cfg_data_bits = 2'(nb - 5);
    cfg_parity    = par;
    cfg_stop2     = stop2;
    settled = 1'b0;
    if (exp_q.size() >= DEPTH) exp_ovr = 1'b1;
    else exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(dm[i]);
    if (pen) drive_bit(pb);
    drive_bit(s1);
    if (stop2) drive_bit(s2);
    rx_serial = 1'b1;
    wait_clk(3 * BIT_CLK);
    settled = 1'b1;
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    wait_clk(1);
    m_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) pop_one();
  endtask

  task automatic clear_ovr();
    ovr_clr = 1'b1;
    wait_clk(1);
    ovr_clr = 1'b0;
  endtask

  initial begin
    wait_clk(90000);
    $display("FAIL watchdog: got no finish, expected end within 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    aresetn = 1'b0; rx_serial = 1'b1; cfg_en = 1'b0; cfg_div = 16'd3;
    cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0; m_ready = 1'b0; ovr_clr = 1'b0;
    wait_clk(3);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_flags", 32'({m_brk, m_ferr, m_perr}), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    aresetn = 1'b1;
    cfg_en  = 1'b1;
    wait_clk(10);
    settled = 1'b1;

    // 8N1 0x55
    send_frame(8'h55, 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_55_data", 32'(m_data), 32'h55);
    chk("lit_55_flags", 32'({m_brk, m_ferr, m_perr}), 32'd0);
    chk("lit_55_level", 32'(fifo_level), 32'd1);
    pop_one();
    chk("lit_55_popped", 32'(fifo_level), 32'd0);

    // 7E1 0x41 with wrong parity bit
    send_frame(8'h41, 7, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_41_data", 32'(m_data), 32'h41);
    chk("lit_41_perr", 32'(m_perr), 32'd1);
    chk("lit_41_ferr", 32'(m_ferr), 32'd0);
    drain();

    // 0xA3 with low stop bit, then line held low for 20 bit times
    settled = 1'b0;
    cfg_data_bits = 2'b11; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    exp_q.push_back({3'b010, 8'hA3});
    exp_q.push_back({3'b110, 8'h00});
    v = 8'hA3;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(v[i]);
    drive_bit(1'b0);
    wait_clk(20 * BIT_CLK);
    rx_serial = 1'b1;
    wait_clk(3 * BIT_CLK);
    settled = 1'b1;
    chk("lit_a3_level", 32'(fifo_level), 32'd2);
    chk("lit_a3_data", 32'(m_data), 32'hA3);
    chk("lit_a3_flags", 32'({m_brk, m_ferr}), 32'b01);
    pop_one();
    chk("lit_brk_entry", 32'({m_brk, m_ferr, m_perr, m_data}), 32'h600);
    pop_one();

    // short low glitch is a false start
    settled = 1'b0;
    rx_serial = 1'b0;
    wait_clk(20);
    rx_serial = 1'b1;
    chk("lit_glitch_busy", 32'(rx_busy), 32'd1);
    wait_clk(100);
    chk("lit_glitch_idle", 32'(rx_busy), 32'd0);
    settled = 1'b1;
    send_frame(8'h3C, 8, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_3c_entry", 32'({m_brk, m_ferr, m_perr, m_data}), 32'h03C);
    drain();

    // fill past depth with no pops
    for (int k = 0; k < 5; k++) send_frame(8'(8'h10 + k), 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_ovr_level", 32'(fifo_level), 32'd4);
    chk("lit_ovr_flag", 32'(overrun), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("lit_ovr_pop", 32'(m_data), 32'(8'h10 + k));
      pop_one();
    end
    clear_ovr();
    chk("lit_ovr_clr", 32'(overrun), 32'd0);

    // async reset mid-frame with an entry held
    send_frame(8'h5A, 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    settled = 1'b0;
    rx_serial = 1'b0;
    wait_clk(150);
    aresetn = 1'b0;
    #1;
    chk("lit_arst_outputs", 32'({m_valid, m_brk, m_ferr, m_perr, m_data}), 32'd0);
    chk("lit_arst_level", 32'({fifo_level, overrun, rx_busy}), 32'd0);
    exp_q.delete();
    exp_ovr = 1'b0;
    rx_serial = 1'b1;
    wait_clk(5);
    aresetn = 1'b1;
    wait_clk(10);
    settled = 1'b1;
    send_frame(8'h7E, 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_7e_entry", 32'({m_brk, m_ferr, m_perr, m_data}), 32'h07E);

    // cfg_en drop mid-frame: frame discarded, FIFO kept, pops still work
    settled = 1'b0;
    rx_serial = 1'b0;
    wait_clk(100);
    chk("lit_en_busy", 32'(rx_busy), 32'd1);
    cfg_en = 1'b0;
    wait_clk(1);
    chk("lit_en_idle", 32'(rx_busy), 32'd0);
    chk("lit_en_kept", 32'(fifo_level), 32'd1);
    pop_one();
    wait_clk(200);
    rx_serial = 1'b1;
    wait_clk(200);
    cfg_en = 1'b1;
    wait_clk(10);
    settled = 1'b1;
    chk("lit_en_level", 32'(fifo_level), 32'd0);

    // randomized frames against the scoreboard
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      send_frame(d, int'($urandom_range(5, 8)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      for (int p = int'($urandom_range(0, 2)); p > 0; p--) pop_one();
      if ($urandom_range(0, 3) == 0) clear_ovr();
    end
    drain();
    wait_clk(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
